// File: rtl/pwm_deadtime.sv
// Complementary gate-drive generator with programmable dead time.
// Splits a single-ended PWM into high/low drives that never overlap.
module pwm_deadtime #(
    parameter int dead_bits = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 pwm_in,
    input  logic [dead_bits-1:0] dead_time,
    output logic                 pwm_hi,
    output logic                 pwm_lo,
    output logic                 dead_active,
    output logic                 swallowed
);

    typedef enum logic [2:0] {
        OFF       = 3'd0,
        LO_ON     = 3'd1,
        DEAD_RISE = 3'd2,
        HI_ON     = 3'd3,
        DEAD_FALL = 3'd4
    } state_t;

    localparam logic [dead_bits-1:0] ONE = {{(dead_bits-1){1'b0}}, 1'b1};

    state_t               r_state;
    state_t               w_next;
    logic [dead_bits-1:0] r_cnt;
    logic [dead_bits-1:0] w_cnt_next;
    logic [dead_bits-1:0] r_dt_q;
    logic [dead_bits-1:0] w_dt_next;
    logic                 w_last;
    logic                 w_swallow;
    logic                 w_hi;
    logic                 w_lo;
    logic                 w_dead;
    logic                 r_hi;
    logic                 r_lo;
    logic                 r_dead;
    logic                 r_swal;

    // A zero latched interval ends after its single entry cycle; cnt+1 cannot
    // overflow because cnt stops at dt_q-1.
    assign w_last = (r_dt_q == '0) || ((r_cnt + ONE) == r_dt_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= OFF;
            r_cnt   <= '0;
            r_dt_q  <= '0;
            r_hi    <= 1'b0;
            r_lo    <= 1'b0;
            r_dead  <= 1'b0;
            r_swal  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_dt_q  <= w_dt_next;
            r_hi    <= w_hi;
            r_lo    <= w_lo;
            r_dead  <= w_dead;
            r_swal  <= w_swallow;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_dt_next  = r_dt_q;
        w_swallow  = 1'b0;
        if (!enable) begin
            w_next     = OFF;
            w_cnt_next = '0;
        end else begin
            unique case (r_state)
                OFF: begin
                    w_next     = pwm_in ? DEAD_RISE : DEAD_FALL;
                    w_dt_next  = dead_time;
                    w_cnt_next = '0;
                end
                LO_ON: begin
                    if (pwm_in) begin
                        if (dead_time == '0) begin
                            w_next = HI_ON;
                        end else begin
                            w_next     = DEAD_RISE;
                            w_dt_next  = dead_time;
                            w_cnt_next = '0;
                        end
                    end
                end
                HI_ON: begin
                    if (!pwm_in) begin
                        if (dead_time == '0) begin
                            w_next = LO_ON;
                        end else begin
                            w_next     = DEAD_FALL;
                            w_dt_next  = dead_time;
                            w_cnt_next = '0;
                        end
                    end
                end
                DEAD_RISE: begin
                    // A reverting input outranks interval completion.
                    if (!pwm_in) begin
                        w_next     = LO_ON;
                        w_swallow  = 1'b1;
                        w_cnt_next = '0;
                    end else if (w_last) begin
                        w_next     = HI_ON;
                        w_cnt_next = '0;
                    end else begin
                        w_cnt_next = r_cnt + ONE;
                    end
                end
                DEAD_FALL: begin
                    if (pwm_in) begin
                        w_next     = HI_ON;
                        w_swallow  = 1'b1;
                        w_cnt_next = '0;
                    end else if (w_last) begin
                        w_next     = LO_ON;
                        w_cnt_next = '0;
                    end else begin
                        w_cnt_next = r_cnt + ONE;
                    end
                end
                default: begin
                    w_next     = OFF;
                    w_cnt_next = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_hi   = (w_next == HI_ON);
        w_lo   = (w_next == LO_ON);
        w_dead = (w_next == DEAD_RISE) || (w_next == DEAD_FALL);
    end

    assign pwm_hi      = r_hi;
    assign pwm_lo      = r_lo;
    assign dead_active = r_dead;
    assign swallowed   = r_swal;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed bench for pwm_deadtime: dead intervals, cancel, reset/disable,
// zero and maximum dead time.
module tb_pwm_deadtime;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       pwm_in;
    logic [7:0] dead_time;
    logic       pwm_hi;
    logic       pwm_lo;
    logic       dead_active;
    logic       swallowed;

    int         errs;
    int         checks;
    logic       e_hi;
    logic       e_lo;
    logic       e_dead;
    logic       e_sw;

    pwm_deadtime #(.dead_bits(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pwm_in     (pwm_in),
        .dead_time  (dead_time),
        .pwm_hi     (pwm_hi),
        .pwm_lo     (pwm_lo),
        .dead_active(dead_active),
        .swallowed  (swallowed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        enable    = 1'b1;
        pwm_in    = 1'b1;
        dead_time = 8'd4;
        tick();
        tick();
        checks++;
        if ({pwm_hi, pwm_lo, dead_active, swallowed} !== 4'b0000) begin
            errs++;
            $display("FAIL reset got=%b exp=0000",
                     {pwm_hi, pwm_lo, dead_active, swallowed});
        end
    endtask

    task automatic test_basic();
        reset     = 1'b0;
        enable    = 1'b1;
        dead_time = 8'd4;
        pwm_in    = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if ({pwm_hi, pwm_lo} !== 2'b01) begin
            errs++;
            $display("FAIL basic_warmup got=%b exp=01", {pwm_hi, pwm_lo});
        end
        for (int i = 0; i < 128; i++) begin
            int p;
            p      = i % 64;
            pwm_in = (p < 32);
            tick();
            e_hi   = (p >= 4) && (p < 32);
            e_lo   = (p >= 36);
            e_dead = (p < 4) || ((p >= 32) && (p < 36));
            checks++;
            if ({pwm_hi, pwm_lo, dead_active, swallowed} !==
                {e_hi, e_lo, e_dead, 1'b0}) begin
                errs++;
                $display("FAIL basic cyc=%0d got=%b exp=%b", i,
                         {pwm_hi, pwm_lo, dead_active, swallowed},
                         {e_hi, e_lo, e_dead, 1'b0});
            end
        end
    endtask

    task automatic test_zero();
        dead_time = 8'd0;
        for (int i = 0; i < 32; i++) begin
            pwm_in = (((i / 8) % 2) == 0);
            tick();
            e_hi = pwm_in;
            e_lo = !pwm_in;
            checks++;
            if ({pwm_hi, pwm_lo, dead_active, swallowed} !==
                {e_hi, e_lo, 1'b0, 1'b0}) begin
                errs++;
                $display("FAIL zero cyc=%0d got=%b exp=%b", i,
                         {pwm_hi, pwm_lo, dead_active, swallowed},
                         {e_hi, e_lo, 1'b0, 1'b0});
            end
        end
    endtask

    task automatic test_cancel();
        dead_time = 8'd10;
        for (int i = 0; i < 10; i++) begin
            pwm_in = (i < 3);
            tick();
            e_dead = (i < 3);
            e_lo   = (i >= 3);
            e_sw   = (i == 3);
            checks++;
            if ({pwm_hi, pwm_lo, dead_active, swallowed} !==
                {1'b0, e_lo, e_dead, e_sw}) begin
                errs++;
                $display("FAIL cancel cyc=%0d got=%b exp=%b", i,
                         {pwm_hi, pwm_lo, dead_active, swallowed},
                         {1'b0, e_lo, e_dead, e_sw});
            end
        end
    endtask

    task automatic test_dt_change();
        dead_time = 8'd4;
        for (int i = 0; i < 30; i++) begin
            pwm_in = (i < 16);
            if (i == 2) dead_time = 8'd9;
            tick();
            e_dead = (i < 4) || ((i >= 16) && (i < 25));
            e_hi   = (i >= 4) && (i < 16);
            e_lo   = (i >= 25);
            checks++;
            if ({pwm_hi, pwm_lo, dead_active, swallowed} !==
                {e_hi, e_lo, e_dead, 1'b0}) begin
                errs++;
                $display("FAIL dtchange cyc=%0d got=%b exp=%b", i,
                         {pwm_hi, pwm_lo, dead_active, swallowed},
                         {e_hi, e_lo, e_dead, 1'b0});
            end
        end
    endtask

    task automatic test_reset_disable();
        dead_time = 8'd4;
        pwm_in    = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if ({pwm_hi, pwm_lo} !== 2'b10) begin
            errs++;
            $display("FAIL pre_reset_hi got=%b exp=10", {pwm_hi, pwm_lo});
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({pwm_hi, pwm_lo, dead_active, swallowed} !== 4'b0000) begin
            errs++;
            $display("FAIL mid_reset got=%b exp=0000",
                     {pwm_hi, pwm_lo, dead_active, swallowed});
        end
        for (int r = 0; r < 2; r++) begin
            enable = 1'b0;
            tick();
            checks++;
            if ({pwm_hi, pwm_lo, dead_active, swallowed} !== 4'b0000) begin
                errs++;
                $display("FAIL disable pass=%0d got=%b exp=0000", r,
                         {pwm_hi, pwm_lo, dead_active, swallowed});
            end
            enable = 1'b1;
            pwm_in = 1'b1;
            for (int i = 0; i < 6; i++) begin
                tick();
                e_dead = (i < 4);
                e_hi   = (i >= 4);
                checks++;
                if ({pwm_hi, pwm_lo, dead_active, swallowed} !==
                    {e_hi, 1'b0, e_dead, 1'b0}) begin
                    errs++;
                    $display("FAIL reenable pass=%0d cyc=%0d got=%b exp=%b",
                             r, i, {pwm_hi, pwm_lo, dead_active, swallowed},
                             {e_hi, 1'b0, e_dead, 1'b0});
                end
            end
        end
    endtask

    task automatic test_max();
        int  n;
        logic bad;
        dead_time = 8'd255;
        for (int d = 0; d < 2; d++) begin
            n      = 0;
            bad    = 1'b0;
            pwm_in = (d == 1);
            for (int i = 0; i < 400; i++) begin
                tick();
                if (pwm_lo || pwm_hi) break;
                if (dead_active) n++;
                else bad = 1'b1;
            end
            checks++;
            if (n != 255 || bad) begin
                errs++;
                $display("FAIL max_len dir=%0d got=%0d exp=255 gap=%b",
                         d, n, bad);
            end
            checks++;
            if ({pwm_hi, pwm_lo} !== ((d == 1) ? 2'b10 : 2'b01)) begin
                errs++;
                $display("FAIL max_end dir=%0d got=%b exp=%b", d,
                         {pwm_hi, pwm_lo}, ((d == 1) ? 2'b10 : 2'b01));
            end
        end
    endtask

    initial begin
        errs   = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_zero();
        test_cancel();
        test_dt_change();
        test_reset_disable();
        test_max();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
